// File: rtl/led_frame_arbiter.sv
// Shares one 8x8 LED scan controller among four frame sources; round-robin with minimum hold,
// content changes only on full-frame boundaries. Optional macro PRIORITY_SRC0_EN: source 0 strict priority.
module led_frame_arbiter #(
  parameter int unsigned PRESCALE     = 5000,
  parameter int unsigned HOLD_FRAMES  = 16,
  parameter logic [63:0] IDLE_PATTERN = 64'h0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [3:0]   req,
  input  logic [255:0] frames_in,
  output logic [3:0]   grant,
  output logic [3:0]   ack,
  output logic [63:0]  matrix_out,
  output logic         time_pulse,
  output logic         busy
);

  localparam int unsigned PW = $clog2(PRESCALE);
  localparam int unsigned HW = $clog2(HOLD_FRAMES + 1);
  localparam logic [PW-1:0] PS_MAX   = PW'(PRESCALE - 1);
  localparam logic [HW-1:0] HOLD_MAX = HW'(HOLD_FRAMES);

  typedef enum logic {IDLE, HOLD} state_e;

  state_e        state_q;
  logic [PW-1:0] prescale_q;
  logic [2:0]    scan_q;
  logic [HW-1:0] hold_q;
  logic [1:0]    last_q;
  logic          time_pulse_q;
  logic [3:0]    grant_q;
  logic [3:0]    ack_q;
  logic [63:0]   matrix_q;
  logic          busy_q;

  logic          frame_tick;
  logic [3:0]    others;
  logic          switch_d;
  logic          release_d;
  logic [1:0]    win_d;
  logic [63:0]   win_frame;
  logic [63:0]   own_frame;

  function automatic logic [1:0] rr_pick(input logic [3:0] r, input logic [1:0] from);
    logic [1:0] idx;
    logic       found;
    rr_pick = from;
    found   = 1'b0;
    for (int unsigned i = 1; i <= 4; i++) begin
      idx = from + 2'(i);
      if (!found && r[idx]) begin
        rr_pick = idx;
        found   = 1'b1;
      end
    end
  endfunction

  assign frame_tick = time_pulse_q && (scan_q == 3'd7);

  // last_q always equals the current owner while in HOLD, so it doubles as g
  always_comb begin
    others    = req & ~(4'b0001 << last_q);
    switch_d  = 1'b0;
    release_d = 1'b0;
    win_d     = last_q;
    if (state_q == IDLE) begin
      if (|req) begin
        switch_d = 1'b1;
        win_d    = rr_pick(req, last_q);
      end
    end else if (!req[last_q]) begin
      if (|others) begin
        switch_d = 1'b1;
        win_d    = rr_pick(others, last_q);
      end else begin
        release_d = 1'b1;
      end
    end else if ((hold_q >= HOLD_MAX) && (|others)) begin
      switch_d = 1'b1;
      win_d    = rr_pick(others, last_q);
    end
`ifdef PRIORITY_SRC0_EN
    if (req[0] && ((state_q == IDLE) || (last_q != 2'd0))) begin
      switch_d  = 1'b1;
      release_d = 1'b0;
      win_d     = 2'd0;
    end else if ((state_q == HOLD) && (last_q == 2'd0) && req[0]) begin
      switch_d  = 1'b0;
      release_d = 1'b0;
      win_d     = 2'd0;
    end
`endif
    win_frame = frames_in[{win_d, 6'd0} +: 64];
    own_frame = frames_in[{last_q, 6'd0} +: 64];
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= IDLE;
      prescale_q   <= '0;
      scan_q       <= '0;
      hold_q       <= '0;
      last_q       <= 2'd3;
      time_pulse_q <= 1'b0;
      grant_q      <= '0;
      ack_q        <= '0;
      matrix_q     <= IDLE_PATTERN;
      busy_q       <= 1'b0;
    end else begin
      prescale_q   <= (prescale_q == PS_MAX) ? '0 : prescale_q + 1'b1;
      time_pulse_q <= (prescale_q == PS_MAX);
      if (time_pulse_q) begin
        scan_q <= scan_q + 1'b1;
      end
      ack_q <= '0;
      if (frame_tick) begin
        if (switch_d) begin
          state_q  <= HOLD;
          last_q   <= win_d;
          grant_q  <= 4'b0001 << win_d;
          ack_q    <= 4'b0001 << win_d;
          matrix_q <= win_frame;
          hold_q   <= HW'(1);
          busy_q   <= 1'b1;
        end else if (release_d) begin
          state_q  <= IDLE;
          grant_q  <= '0;
          matrix_q <= IDLE_PATTERN;
          busy_q   <= 1'b0;
        end else if (state_q == HOLD) begin
          ack_q    <= 4'b0001 << last_q;
          matrix_q <= own_frame;
          if (hold_q < HOLD_MAX) begin
            hold_q <= hold_q + 1'b1;
          end
        end
      end
    end
  end

  assign grant      = grant_q;
  assign ack        = ack_q;
  assign matrix_out = matrix_q;
  assign time_pulse = time_pulse_q;
  assign busy       = busy_q;

endmodule

// File: doc/led_frame_arbiter.md
Name: led_frame_arbiter

Overview:
- Shares the 8x8 LED matrix scan controller among 4 frame sources (e.g. game field, score, text scroller, test pattern).
- Generates the scan-step pulse for the scan controller.
- Selects which source's 64-bit frame is displayed, using round-robin with a minimum hold time.
- Changes displayed content only on full-frame boundaries, so the display never tears.

Parameters:
- PRESCALE, 5000: clk cycles per scan-step pulse (minimum 2).
- HOLD_FRAMES, 16: full frames (8 scan steps each) a grant is held before another requester can take over (minimum 1).
- IDLE_PATTERN, 64'h0: frame driven when no source holds the display.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous, active-low reset
- req  input  4  per-source display request, level, held while the source wants the display
- frames_in  input  256  source i frame on bits [64*i+63:64*i]; row1 in each frame's MSB byte
- grant  output  4  one-hot owner of the display; 0 when idle
- ack  output  4  one-cycle pulse to a source when its frame is latched into matrix_out
- matrix_out  output  64  frame to the scan controller's matrix input
- time_pulse  output  1  one-cycle scan-step pulse to the scan controller
- busy  output  1  high while any source holds the display

Behaviour:
Reset (rst==0 at posedge clk):
- grant=0, ack=0, matrix_out=IDLE_PATTERN, time_pulse=0, busy=0.
- prescale_cnt=0, scan_cnt=0, hold_cnt=0.
- RR pointer last=3, so source 0 wins first. State=IDLE.
- Reset mid-grant takes effect immediately, with no completion of the frame.

Prescaler and scan counter:
- prescale_cnt counts 0..PRESCALE-1 and wraps.
- time_pulse=1 for exactly the cycle after prescale_cnt==PRESCALE-1, so its period is PRESCALE cycles.
- scan_cnt (3 bits) increments on each time_pulse and wraps 7->0.
- frame_tick = time_pulse && scan_cnt==7.
- Both counters free-run in every state.

Arbitration, evaluated only on frame_tick cycles:
- Round-robin: search req starting at last+1 mod 4, wrap, first set bit wins. winner->last on grant.
- IDLE, frame_tick, req!=0: next cycle grant=onehot(winner), ack[winner]=1 for one cycle, matrix_out=frame of winner, hold_cnt=1, busy=1, state->HOLD.
- IDLE, req==0: matrix_out stays IDLE_PATTERN.
- HOLD, frame_tick, with g = the current owner:
  - req[g]==0 and other requests present: hand over to RR winner among the others (ack pulse, hold_cnt=1).
  - req[g]==0 and no other requests: grant=0, busy=0, matrix_out=IDLE_PATTERN, state->IDLE.
  - req[g]==1, hold_cnt>=HOLD_FRAMES, another source requesting: hand over to RR winner excluding g.
  - otherwise: keep g, matrix_out re-latched from g's frame (refreshes content, ack[g] pulses), hold_cnt increments saturating at HOLD_FRAMES.
- Between frame_ticks: matrix_out, grant and state are stable regardless of req or frames_in changes.
- A req dropped and re-raised between ticks is invisible.
- ack is never asserted on more than one bit; ack is asserted exactly when matrix_out updates from a source.

Widths:
- prescale_cnt is $clog2(PRESCALE) bits.
- hold_cnt is $clog2(HOLD_FRAMES+1) bits.

Optional Feature:
PRIORITY_SRC0_EN:
- Defined: source 0 is strict priority.
  - On any frame_tick with req[0]==1 and g!=0, ownership goes to source 0 regardless of hold_cnt (last=0, ack[0] pulse).
  - While source 0 holds and req[0]==1, it is never rotated out, even at hold_cnt>=HOLD_FRAMES.
- Undefined: source 0 is an ordinary round-robin participant.

Test Plan:
All scenarios use PRESCALE=4, HOLD_FRAMES=2, so a frame period is 32 clk cycles.
- Reset release, req=0: time_pulse pulses every 4 cycles; matrix_out=0 and grant=0 for 200 cycles.
- req=4'b0100, frames_in[191:128]=64'hA5A5_A5A5_A5A5_A5A5: at first frame_tick +1 cycle, grant=0100 and ack=0100 for one cycle; matrix_out=A5A5...; busy=1.
- req=4'b0011 held, distinct frames: grant sequence 0001 (2 frames) -> 0010 (2 frames) -> 0001; each change exactly on a frame_tick +1 cycle.
- Owner drops req mid-frame: display unchanged until the next frame_tick; then grant=0, matrix_out=IDLE_PATTERN, busy=0.
- Change frames_in of the owner mid-frame: matrix_out unchanged until the next frame_tick, then shows the new value with an ack pulse.
- PRIORITY_SRC0_EN defined, source 2 holding at hold_cnt=1, raise req[0]: next frame_tick gives grant=0001; with req=4'b0101 held, grant stays 0001 indefinitely.
